// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RF_AW  = 5;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_REQ    = 2'd1,
    LSU_WAIT_R = 2'd2,
    LSU_DONE   = 2'd3
  } lsu_state_e;

  // funct3 size codes shared by loads and stores
  localparam logic [SIZE_W-1:0] INST_LB  = 3'b000;
  localparam logic [SIZE_W-1:0] INST_LH  = 3'b001;
  localparam logic [SIZE_W-1:0] INST_LW  = 3'b010;
  localparam logic [SIZE_W-1:0] INST_LBU = 3'b100;
  localparam logic [SIZE_W-1:0] INST_LHU = 3'b101;
  localparam logic [SIZE_W-1:0] INST_SB  = 3'b000;
  localparam logic [SIZE_W-1:0] INST_SH  = 3'b001;
  localparam logic [SIZE_W-1:0] INST_SW  = 3'b010;

  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  // Request captured in IDLE and replayed on the bus
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [BE_W-1:0]   be;
    logic              we;
    logic [SIZE_W-1:0] size;
    logic [RF_AW-1:0]  rd_addr;
    logic              rd_wen;
  } lsu_req_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane formatting: store replication/BE, load extract/extend, legality check.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]        st_addr_lo,
  input  logic [SIZE_W-1:0] st_size,
  input  logic              st_we,
  input  logic              st_re,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata_c,
  output logic [BE_W-1:0]   st_be_c,
  output logic              illegal_c,
  input  logic [1:0]        ld_addr_lo,
  input  logic [SIZE_W-1:0] ld_size,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data_c
);

  logic misalign;
  logic bad_st;
  logic bad_ld;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  // Store lane replication and byte enables
  always_comb begin
    st_wdata_c = st_data;
    st_be_c    = BE_WORD;
    case (st_size)
      INST_SB: begin
        st_wdata_c = {4{st_data[7:0]}};
        st_be_c    = BE_BYTE << st_addr_lo;
      end
      INST_SH: begin
        st_wdata_c = {2{st_data[15:0]}};
        st_be_c    = BE_HALF << st_addr_lo;
      end
      default: ;
    endcase
  end

  // Misalignment, illegal size and conflicting we/re detection
  always_comb begin
    misalign  = ((st_size[1:0] == 2'b01) && st_addr_lo[0]) ||
                ((st_size[1:0] == 2'b10) && (st_addr_lo != 2'b00));
    bad_st    = st_we && !((st_size == INST_SB) || (st_size == INST_SH) || (st_size == INST_SW));
    bad_ld    = st_re && ((st_size == 3'b011) || (st_size == 3'b110) || (st_size == 3'b111));
    illegal_c = (st_we && st_re) || ((st_we || st_re) && (misalign || bad_st || bad_ld));
  end

  // Load extraction with sign or zero extension
  always_comb begin
    ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    ld_sext = !ld_size[2];
    case (ld_size[1:0])
      2'b00:   ld_data_c = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data_c = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage LSU: single-outstanding req/gnt/rvalid bus access with pipeline hold.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [SIZE_W-1:0] mem_size_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [RF_AW-1:0]  rd_addr_i,
  input  logic              rd_wen_i,
  input  logic [XLEN-1:0]   rd_data_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [BE_W-1:0]   bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic [RF_AW-1:0]  rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_wen_o,
  output logic              hold_flag_o,
  output logic              lsu_err_o
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  lsu_req_t         cap_q;
  logic [XLEN-1:0]  result_q;
  logic [XLEN-1:0]  st_wdata;
  logic [BE_W-1:0]  st_be;
  logic             illegal;
  logic [XLEN-1:0]  ld_data;
  logic             capture_en;
  logic             result_en;
  logic             timeout;

  mem_lsu_align u_align (
    .st_addr_lo (mem_addr_i[1:0]),
    .st_size    (mem_size_i),
    .st_we      (mem_we_i),
    .st_re      (mem_re_i),
    .st_data    (mem_data_i),
    .st_wdata_c (st_wdata),
    .st_be_c    (st_be),
    .illegal_c  (illegal),
    .ld_addr_lo (cap_q.addr[1:0]),
    .ld_size    (cap_q.size),
    .ld_rdata   (bus_rdata_i),
    .ld_data_c  (ld_data)
  );

  assign timeout     = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT));
  assign bus_addr_o  = {cap_q.addr[XLEN-1:2], 2'b00};
  assign bus_wdata_o = cap_q.wdata;
  assign bus_be_o    = cap_q.be;

  // Next-state, handshake, hold and writeback decode
  always_comb begin
    state_d     = state_q;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    hold_flag_o = 1'b0;
    lsu_err_o   = 1'b0;
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    capture_en  = 1'b0;
    result_en   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (!(mem_we_i || mem_re_i)) begin
          rd_addr_o = rd_addr_i;
          rd_data_o = rd_data_i;
          rd_wen_o  = rd_wen_i;
        end else if (illegal) begin
          lsu_err_o = 1'b1;
        end else begin
          hold_flag_o = 1'b1;
          capture_en  = 1'b1;
          state_d     = LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (timeout) begin
          lsu_err_o = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          bus_req_o   = 1'b1;
          bus_we_o    = cap_q.we;
          hold_flag_o = 1'b1;
          if (bus_gnt_i) state_d = cap_q.we ? LSU_DONE : LSU_WAIT_R;
        end
      end
      LSU_WAIT_R: begin
        if (timeout) begin
          lsu_err_o = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          hold_flag_o = 1'b1;
          if (bus_rvalid_i) begin
            result_en = 1'b1;
            state_d   = LSU_DONE;
          end
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
        if (!cap_q.we && cap_q.rd_wen) begin
          rd_wen_o  = 1'b1;
          rd_addr_o = cap_q.rd_addr;
          rd_data_o = result_q;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // Bus wait counter: runs in REQ/WAIT_R, clears on any state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((BUS_TIMEOUT == 0) || (state_d != state_q) ||
                 !((state_q == LSU_REQ) || (state_q == LSU_WAIT_R))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Request capture; loads always read the full word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (capture_en) begin
      cap_q.addr    <= mem_addr_i;
      cap_q.wdata   <= st_wdata;
      cap_q.be      <= mem_we_i ? st_be : BE_WORD;
      cap_q.we      <= mem_we_i;
      cap_q.size    <= mem_size_i;
      cap_q.rd_addr <= rd_addr_i;
      cap_q.rd_wen  <= rd_wen_i;
    end
  end

  // Formatted load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         result_q <= '0;
    else if (result_en) result_q <= ld_data;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a short bus timeout.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr_i, mem_data_i, rd_data_i, bus_rdata_i;
  logic [2:0]  mem_size_i;
  logic        mem_we_i, mem_re_i, rd_wen_i;
  logic [4:0]  rd_addr_i;
  logic        bus_gnt_i, bus_rvalid_i;
  logic        bus_req_o, bus_we_o, rd_wen_o, hold_flag_o, lsu_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, rd_data_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_size_i(mem_size_i),
    .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .rd_data_i(rd_data_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .hold_flag_o(hold_flag_o), .lsu_err_o(lsu_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_addr_i = '0; mem_data_i = '0; mem_size_i = '0;
    mem_we_i = 1'b0; mem_re_i = 1'b0;
    rd_addr_i = '0; rd_wen_i = 1'b0; rd_data_i = '0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] expv);
    mem_addr_i = a; mem_size_i = sz; mem_re_i = 1'b1; mem_we_i = 1'b0;
    rd_addr_i = rd; rd_wen_i = 1'b1; rd_data_i = 32'hDEAD_0000;
    #1;
    chk({tag, "_idle_hold"}, 32'(hold_flag_o), 32'd1);
    chk({tag, "_idle_wen"}, 32'(rd_wen_o), 32'd0);
    tick();
    bus_gnt_i = 1'b1;
    #1;
    chk({tag, "_req"}, 32'(bus_req_o), 32'd1);
    chk({tag, "_be"}, 32'(bus_be_o), 32'hF);
    chk({tag, "_addr"}, bus_addr_o, {a[31:2], 2'b00});
    chk({tag, "_we"}, 32'(bus_we_o), 32'd0);
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = rdata;
    #1;
    chk({tag, "_wait_hold"}, 32'(hold_flag_o), 32'd1);
    chk({tag, "_wait_wen"}, 32'(rd_wen_o), 32'd0);
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #1;
    chk({tag, "_done_wen"}, 32'(rd_wen_o), 32'd1);
    chk({tag, "_done_rd"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, "_done_data"}, rd_data_o, expv);
    chk({tag, "_done_hold"}, 32'(hold_flag_o), 32'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #1;
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_hold", 32'(hold_flag_o), 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    chk("rst_wen", 32'(rd_wen_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // SB 0x1003, grant on second REQ cycle
    mem_addr_i = 32'h1003; mem_data_i = 32'h0000_00A5; mem_size_i = 3'b000; mem_we_i = 1'b1;
    #1;
    chk("sb_idle_hold", 32'(hold_flag_o), 32'd1);
    chk("sb_idle_req", 32'(bus_req_o), 32'd0);
    tick();
    #1;
    chk("sb_req1", 32'(bus_req_o), 32'd1);
    chk("sb_addr", bus_addr_o, 32'h1000);
    chk("sb_wdata", bus_wdata_o, 32'hA5A5_A5A5);
    chk("sb_be", 32'(bus_be_o), 32'h8);
    chk("sb_we", 32'(bus_we_o), 32'd1);
    chk("sb_req1_hold", 32'(hold_flag_o), 32'd1);
    tick();
    bus_gnt_i = 1'b1;
    #1;
    chk("sb_req2", 32'(bus_req_o), 32'd1);
    chk("sb_req2_hold", 32'(hold_flag_o), 32'd1);
    chk("sb_req2_wen", 32'(rd_wen_o), 32'd0);
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("sb_done_hold", 32'(hold_flag_o), 32'd0);
    chk("sb_done_wen", 32'(rd_wen_o), 32'd0);
    chk("sb_done_req", 32'(bus_req_o), 32'd0);
    tick();
    idle_inputs();

    // SH 0x1002, immediate grant
    mem_addr_i = 32'h1002; mem_data_i = 32'h1234_BEEF; mem_size_i = 3'b001; mem_we_i = 1'b1;
    tick();
    bus_gnt_i = 1'b1;
    #1;
    chk("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
    chk("sh_be", 32'(bus_be_o), 32'hC);
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("sh_done_wen", 32'(rd_wen_o), 32'd0);
    tick();
    idle_inputs();

    // Loads: extraction and extension
    do_load("lb",  32'h2001, 3'b000, 32'h1234_80FF, 5'd7,  32'hFFFF_FF80);
    do_load("lbu", 32'h2001, 3'b100, 32'h1234_80FF, 5'd8,  32'h0000_0080);
    do_load("lhu", 32'h2002, 3'b101, 32'h1234_80FF, 5'd9,  32'h0000_1234);
    do_load("lh",  32'h2002, 3'b001, 32'h8001_0000, 5'd10, 32'hFFFF_8001);
    do_load("lw",  32'h2004, 3'b010, 32'hCAFE_BABE, 5'd11, 32'hCAFE_BABE);

    // ADD directly after the LW: passthrough, same cycle
    idle_inputs();
    rd_addr_i = 5'd5; rd_data_i = 32'h55; rd_wen_i = 1'b1;
    #1;
    chk("add_rd", 32'(rd_addr_o), 32'd5);
    chk("add_data", rd_data_o, 32'h55);
    chk("add_wen", 32'(rd_wen_o), 32'd1);
    chk("add_hold", 32'(hold_flag_o), 32'd0);
    tick();
    idle_inputs();

    // Misaligned LW
    mem_addr_i = 32'h3002; mem_size_i = 3'b010; mem_re_i = 1'b1; rd_addr_i = 5'd3; rd_wen_i = 1'b1;
    #1;
    chk("lwmis_err", 32'(lsu_err_o), 32'd1);
    chk("lwmis_hold", 32'(hold_flag_o), 32'd0);
    chk("lwmis_wen", 32'(rd_wen_o), 32'd0);
    chk("lwmis_rd", 32'(rd_addr_o), 32'd0);
    chk("lwmis_req", 32'(bus_req_o), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("lwmis_after_req", 32'(bus_req_o), 32'd0);
    chk("lwmis_after_err", 32'(lsu_err_o), 32'd0);

    // Illegal store size, we&re together, odd halfword
    mem_addr_i = 32'h1000; mem_size_i = 3'b100; mem_we_i = 1'b1;
    #1;
    chk("sbad_err", 32'(lsu_err_o), 32'd1);
    mem_size_i = 3'b010; mem_re_i = 1'b1;
    #1;
    chk("wer_err", 32'(lsu_err_o), 32'd1);
    mem_re_i = 1'b0; mem_addr_i = 32'h1001; mem_size_i = 3'b001;
    #1;
    chk("shmis_err", 32'(lsu_err_o), 32'd1);
    chk("shmis_hold", 32'(hold_flag_o), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("illegal_idle_req", 32'(bus_req_o), 32'd0);

    // Timeout: SW never granted
    mem_addr_i = 32'h4000; mem_data_i = 32'h1111_2222; mem_size_i = 3'b010; mem_we_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_req", 32'(bus_req_o), 32'd1);
      chk("to_noerr", 32'(lsu_err_o), 32'd0);
      tick();
    end
    #1;
    chk("to_err", 32'(lsu_err_o), 32'd1);
    chk("to_req_drop", 32'(bus_req_o), 32'd0);
    chk("to_hold_drop", 32'(hold_flag_o), 32'd0);
    tick();
    idle_inputs();
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    #1;
    chk("to_late_req", 32'(bus_req_o), 32'd0);
    chk("to_late_err", 32'(lsu_err_o), 32'd0);
    tick();
    #1;
    chk("to_late_wen", 32'(rd_wen_o), 32'd0);
    chk("to_late_hold", 32'(hold_flag_o), 32'd0);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    tick();

    // Reset asserted during WAIT_R
    mem_addr_i = 32'h5000; mem_size_i = 3'b010; mem_re_i = 1'b1; rd_addr_i = 5'd12; rd_wen_i = 1'b1;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("rmid_wait_hold", 32'(hold_flag_o), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rmid_req", 32'(bus_req_o), 32'd0);
    chk("rmid_hold", 32'(hold_flag_o), 32'd0);
    tick();
    rst_n = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hABCD_0123;
    #1;
    chk("rmid_rv_wen", 32'(rd_wen_o), 32'd0);
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("rmid_after_wen", 32'(rd_wen_o), 32'd0);
    chk("rmid_after_data", rd_data_o, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
